mdrv_merge_reg: RTL and testbench

- Parametrised successor to the two-process overlapping-write register.
- NCH independent write channels each update a per-bit-masked subset of one WIDTH-bit register (bits indexed 0..WIDTH-1, bit 0 first).
- Overlaps are resolved deterministically by a single merge process, so every register bit has exactly one driver.
- Each overlap is recorded in sticky per-bit flags and a saturating counter; the block sits between config/status writers and the consumers of the merged register.

---
 rtl/mdrv_merge_reg_if.sv | 27 ++
 rtl/mdrv_merge_reg.sv | 91 +++++++++
 tb/tb_mdrv_merge_reg.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mdrv_merge_reg_if.sv
// mdrv_merge_reg_if: write-channel and status bundle for the merged register
//   master drives: wr_vld[NCH], wr_mask/wr_data[NCH*WIDTH] (slice c = [c*WIDTH +: WIDTH]), clr_stat
//   slave drives:  aa[WIDTH], upd, conflict_bits[WIDTH], conflict_cnt[CNT_W], owner[WIDTH*$clog2(NCH)]
interface mdrv_merge_reg_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 2,
  parameter int CNT_W = 8
);
  localparam int OW = $clog2(NCH);
  logic [NCH-1:0]       wr_vld;
  logic [NCH*WIDTH-1:0] wr_mask;
  logic [NCH*WIDTH-1:0] wr_data;
  logic                 clr_stat;
  logic [WIDTH-1:0]     aa;
  logic                 upd;
  logic [WIDTH-1:0]     conflict_bits;
  logic [CNT_W-1:0]     conflict_cnt;
  logic [WIDTH*OW-1:0]  owner;
  modport master (
    output wr_vld, wr_mask, wr_data, clr_stat,
    input  aa, upd, conflict_bits, conflict_cnt, owner
  );
  modport slave (
    input  wr_vld, wr_mask, wr_data, clr_stat,
    output aa, upd, conflict_bits, conflict_cnt, owner
  );
endinterface

// File: rtl/mdrv_merge_reg.sv
// mdrv_merge_reg: NCH-channel bit-masked register merge with conflict tracking
//   clk, rst (async active-high); bus = mdrv_merge_reg_if.slave
//   Define MDRV_MERGE_RR_EN for round-robin priority; otherwise lowest channel wins.
module mdrv_merge_reg #(
  parameter int               WIDTH   = 8,
  parameter int               NCH     = 2,
  parameter int               CNT_W   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic              clk,
  input logic              rst,
  mdrv_merge_reg_if.slave  bus
);
  localparam int OW = $clog2(NCH);
  logic [WIDTH-1:0]    aa_q, req, con;
  logic                upd_q;
  logic [WIDTH-1:0]    cbits;
  logic [CNT_W-1:0]    cnt;
  logic [WIDTH*OW-1:0] own_q;
  logic [NCH-1:0]      rq [WIDTH];
  logic [OW-1:0]       win [WIDTH];
  // clears the lowest set bit; anything left means two or more requesters
  function automatic logic multi(input logic [NCH-1:0] r);
    multi = |(r & (r - NCH'(1)));
  endfunction
`ifdef MDRV_MERGE_RR_EN
  logic [OW-1:0] rr_ptr;
  // scan in reverse priority order so the last hit is the highest-priority requester
  function automatic logic [OW-1:0] pick(input logic [NCH-1:0] r, input logic [OW-1:0] p);
    pick = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (r[(int'(p) + k) % NCH]) pick = OW'((int'(p) + k) % NCH);
  endfunction
`else
  function automatic logic [OW-1:0] pick(input logic [NCH-1:0] r);
    pick = '0;
    for (int c = NCH - 1; c >= 0; c--)
      if (r[c]) pick = OW'(c);
  endfunction
`endif
  always_comb begin
    for (int b = 0; b < WIDTH; b++) begin
      for (int c = 0; c < NCH; c++) rq[b][c] = bus.wr_vld[c] & bus.wr_mask[c*WIDTH+b];
      req[b] = |rq[b];
      con[b] = multi(rq[b]);
`ifdef MDRV_MERGE_RR_EN
      win[b] = pick(rq[b], rr_ptr);
`else
      win[b] = pick(rq[b]);
`endif
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aa_q  <= RST_VAL;
      own_q <= '0;
      upd_q <= 1'b0;
    end else begin
      for (int b = 0; b < WIDTH; b++)
        if (req[b]) begin
          aa_q[b]            <= bus.wr_data[int'(win[b])*WIDTH+b];
          own_q[b*OW +: OW]  <= win[b];
        end
      upd_q <= |req;
    end
  end
  // a clear coinciding with a conflict restarts the statistics from that conflict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cbits <= '0;
      cnt   <= '0;
    end else if (bus.clr_stat) begin
      cbits <= con;
      cnt   <= |con ? CNT_W'(1) : '0;
    end else begin
      cbits <= cbits | con;
      if (|con && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
  end
`ifdef MDRV_MERGE_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr <= '0;
    else if (|con) rr_ptr <= (rr_ptr == OW'(NCH - 1)) ? '0 : rr_ptr + OW'(1);
  end
`endif
  assign bus.aa            = aa_q;
  assign bus.upd           = upd_q;
  assign bus.conflict_bits = cbits;
  assign bus.conflict_cnt  = cnt;
  assign bus.owner         = own_q;
endmodule

// File: tb/tb_mdrv_merge_reg.sv
// tb_mdrv_merge_reg: directed checks of the merged register, WIDTH=8 NCH=2 CNT_W=2 RST_VAL=A5
module tb_mdrv_merge_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  mdrv_merge_reg_if #(.WIDTH(8), .NCH(2), .CNT_W(2)) bus ();
  mdrv_merge_reg #(.WIDTH(8), .NCH(2), .CNT_W(2), .RST_VAL(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [1:0] v, input logic [7:0] m0, d0, m1, d1, input logic clr);
    bus.wr_vld   = v;
    bus.wr_mask  = {m1, m0};
    bus.wr_data  = {d1, d0};
    bus.clr_stat = clr;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    #12 rst = 1'b0;
    chk("rst_aa", 32'(bus.aa), 32'hA5);
    chk("rst_upd", 32'(bus.upd), 32'h0);
    chk("rst_cnt", 32'(bus.conflict_cnt), 32'h0);
    chk("rst_owner", 32'(bus.owner), 32'h0);
    chk("rst_cbits", 32'(bus.conflict_bits), 32'h0);
    drive(2'b11, 8'h07, 8'hFF, 8'hF8, 8'h00, 1'b0);
    tick;
    chk("disj_aa", 32'(bus.aa), 32'h07);
    chk("disj_upd", 32'(bus.upd), 32'h1);
    chk("disj_cbits", 32'(bus.conflict_bits), 32'h0);
    chk("disj_owner", 32'(bus.owner), 32'hF8);
    drive(2'b00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    tick;
    chk("idle_upd", 32'(bus.upd), 32'h0);
    chk("idle_aa", 32'(bus.aa), 32'h07);
    drive(2'b11, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0);
    tick;
    chk("zmask_upd", 32'(bus.upd), 32'h0);
    chk("zmask_aa", 32'(bus.aa), 32'h07);
    drive(2'b11, 8'h0F, 8'hFF, 8'hF8, 8'h00, 1'b0);
    tick;
    chk("ovl_aa", 32'(bus.aa), 32'h0F);
    chk("ovl_owner", 32'(bus.owner), 32'hF0);
    chk("ovl_cbits", 32'(bus.conflict_bits), 32'h08);
    chk("ovl_cnt", 32'(bus.conflict_cnt), 32'h1);
    drive(2'b11, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0);
    rst = 1'b1;
    #1;
    chk("mrst_aa", 32'(bus.aa), 32'hA5);
    chk("mrst_upd", 32'(bus.upd), 32'h0);
    chk("mrst_cnt", 32'(bus.conflict_cnt), 32'h0);
    chk("mrst_owner", 32'(bus.owner), 32'h0);
    chk("mrst_cbits", 32'(bus.conflict_bits), 32'h0);
    #1 rst = 1'b0;
    drive(2'b11, 8'h0F, 8'hFF, 8'hF8, 8'h00, 1'b0);
    tick;
    chk("rep1_aa", 32'(bus.aa), 32'h0F);
    chk("rep1_cnt", 32'(bus.conflict_cnt), 32'h1);
    tick;
`ifdef MDRV_MERGE_RR_EN
    chk("rep2_aa", 32'(bus.aa), 32'h07);
    chk("rep2_owner", 32'(bus.owner), 32'hF8);
`else
    chk("rep2_aa", 32'(bus.aa), 32'h0F);
    chk("rep2_owner", 32'(bus.owner), 32'hF0);
`endif
    chk("rep2_cnt", 32'(bus.conflict_cnt), 32'h2);
    tick;
    chk("rep3_aa", 32'(bus.aa), 32'h0F);
    chk("rep3_cnt", 32'(bus.conflict_cnt), 32'h3);
    drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    tick;
    chk("clr1_cnt", 32'(bus.conflict_cnt), 32'h0);
    chk("clr1_cbits", 32'(bus.conflict_bits), 32'h0);
    chk("clr1_upd", 32'(bus.upd), 32'h0);
    drive(2'b11, 8'h0F, 8'hFF, 8'hF8, 8'h00, 1'b0);
    tick;
    chk("sat1", 32'(bus.conflict_cnt), 32'h1);
    tick;
    chk("sat2", 32'(bus.conflict_cnt), 32'h2);
    tick;
    chk("sat3", 32'(bus.conflict_cnt), 32'h3);
    tick;
    chk("sat4", 32'(bus.conflict_cnt), 32'h3);
    tick;
    chk("sat5", 32'(bus.conflict_cnt), 32'h3);
`ifdef MDRV_MERGE_RR_EN
    chk("sat5_aa", 32'(bus.aa), 32'h07);
`else
    chk("sat5_aa", 32'(bus.aa), 32'h0F);
`endif
    drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    tick;
    chk("clr2_cnt", 32'(bus.conflict_cnt), 32'h0);
    chk("clr2_cbits", 32'(bus.conflict_bits), 32'h0);
    drive(2'b11, 8'h0F, 8'hFF, 8'hF8, 8'h00, 1'b0);
    tick;
    chk("pre_cbits", 32'(bus.conflict_bits), 32'h08);
    drive(2'b11, 8'h20, 8'h20, 8'h20, 8'h00, 1'b1);
    tick;
    chk("clrc_cbits", 32'(bus.conflict_bits), 32'h20);
    chk("clrc_cnt", 32'(bus.conflict_cnt), 32'h1);
    chk("clrc_upd", 32'(bus.upd), 32'h1);
`ifdef MDRV_MERGE_RR_EN
    chk("clrc_aa", 32'(bus.aa), 32'h0F);
`else
    chk("clrc_aa", 32'(bus.aa), 32'h2F);
`endif
    drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tick;
    chk("hold_cbits", 32'(bus.conflict_bits), 32'h20);
    chk("hold_cnt", 32'(bus.conflict_cnt), 32'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
